vga_timing_gen: RTL

- Produces the raster scan consumed by every sprite and background block: DrawX/DrawY pixel coordinates, the blank (visible-region) qualifier, and hsync/vsync for the 640x480@60 Hz monitor.
- Runs on vga_clk (25 MHz pixel clock).
- Sprite readers fetch ROM data on the negedge and latch colour on the posedge, so every output here is registered on the posedge and mutually aligned.
- Also provides frame/vblank strobes so game logic updates sprite positions between frames.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_axis_counter.sv | 46 ++++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and types for the 640x480@60 Hz raster generator and
// for the sprite ROM address logic that consumes the raster coordinates.
//   - Default horizontal/vertical timing in pixels/lines.
//   - Derived totals and sync window bounds (start inclusive, end exclusive).
//   - coord_t: the 10-bit pixel/line coordinate type.
//   - in_window(): half-open range test used by the sync decoders.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  localparam int HS_START = H_VISIBLE + H_FRONT;                   // 656
  localparam int HS_END   = HS_START + H_SYNC;                     // 752
  localparam int VS_START = V_VISIBLE + V_FRONT;                   // 490
  localparam int VS_END   = VS_START + V_SYNC;                     // 492

  localparam int FRAME_CNT_W = 16;

  typedef logic [9:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Raster bundle produced by vga_timing_gen and consumed by sprite/background
// blocks. All signals are registered on the posedge of vga_clk and aligned.
//   DrawX, DrawY   current pixel column / line
//   blank          1 = visible pixel
//   hsync, vsync   active-low sync pulses
//   frame_start    1-cycle pulse at (0,0)
//   vblank_start   1-cycle pulse at (0,V_VISIBLE)
//   frame_count    completed-frame counter (0 when the counter is not built)
// Modports: master (timing generator), slave (raster consumers).
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t                 DrawX;
  coord_t                 DrawY;
  logic                   blank;
  logic                   hsync;
  logic                   vsync;
  logic                   frame_start;
  logic                   vblank_start;
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hsync, vsync, frame_start, vblank_start, frame_count
  );

  modport slave (
    input  DrawX, DrawY, blank, hsync, vsync, frame_start, vblank_start, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: counts 0..MAX_COUNT while enabled, then wraps to 0.
//   clk         clock, posedge
//   rst_n       asynchronous active-low reset (count -> 0)
//   en          advance this cycle
//   count       registered current value
//   count_next  value count takes at the next posedge (lets the parent decode
//               registered qualifiers with zero skew to the coordinates)
//   tc          terminal count: count == MAX_COUNT
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 799
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t count,
  output coord_t count_next,
  output logic   tc
);

  assign tc = (count == coord_t'(MAX_COUNT));

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    count_next = count;
    if (en) begin
      count_next = tc ? '0 : count + coord_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz raster generator on the 25 MHz pixel clock. A horizontal and a
// vertical vga_axis_counter produce DrawX/DrawY; blank, hsync, vsync,
// frame_start and vblank_start are decoded from the counters' next-state
// values and registered, so they line up exactly with the coordinates shown
// in the same cycle. Nothing combinational reaches the outputs except reset.
//   vga_clk   pixel clock, all logic on posedge
//   reset_n   asynchronous active-low reset; outputs return to position (0,0)
//   vga       vga_timing_gen_if.master raster bundle
// Build option:
//   VGA_FRAME_CNT_EN  defined: frame_count counts completed frames (mod 2^16),
//                     incrementing on the (H_TOTAL-1,V_TOTAL-1)->(0,0) wrap.
//                     undefined: frame_count is tied to zero, no register.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  vga_timing_pkg::coord_t x_q, x_d;
  vga_timing_pkg::coord_t y_q, y_d;
  logic                   h_tc, v_tc;
  logic                   frame_wrap;

  vga_axis_counter #(.MAX_COUNT(H_TOTAL - 1)) u_h_cnt (
    .clk        (vga_clk),
    .rst_n      (reset_n),
    .en         (1'b1),
    .count      (x_q),
    .count_next (x_d),
    .tc         (h_tc)
  );

  vga_axis_counter #(.MAX_COUNT(V_TOTAL - 1)) u_v_cnt (
    .clk        (vga_clk),
    .rst_n      (reset_n),
    .en         (h_tc),
    .count      (y_q),
    .count_next (y_d),
    .tc         (v_tc)
  );

  // Last pixel of the frame: the next edge moves both counters to (0,0).
  assign frame_wrap = h_tc & v_tc;

  // Qualifiers for the position the counters will hold after the next edge.
  logic blank_d, hsync_d, vsync_d, vblank_start_d;

  always_comb begin
    blank_d        = (x_d < vga_timing_pkg::coord_t'(H_VISIBLE)) &&
                     (y_d < vga_timing_pkg::coord_t'(V_VISIBLE));
    hsync_d        = !vga_timing_pkg::in_window(x_d,
                        vga_timing_pkg::coord_t'(HS_START),
                        vga_timing_pkg::coord_t'(HS_END));
    vsync_d        = !vga_timing_pkg::in_window(y_d,
                        vga_timing_pkg::coord_t'(VS_START),
                        vga_timing_pkg::coord_t'(VS_END));
    vblank_start_d = (x_d == '0) && (y_d == vga_timing_pkg::coord_t'(V_VISIBLE));
  end

  logic blank_q, hsync_q, vsync_q, frame_start_q, vblank_start_q;

  // NOTE: reset values describe position (0,0) so the outputs stay mutually
  // consistent while reset is held: visible, syncs idle, frame_start high.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q        <= 1'b1;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      frame_start_q  <= 1'b1;
      vblank_start_q <= 1'b0;
    end else begin
      blank_q        <= blank_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      frame_start_q  <= frame_wrap;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign vga.DrawX        = x_q;
  assign vga.DrawY        = y_q;
  assign vga.blank        = blank_q;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.vblank_start = vblank_start_q;

`ifdef VGA_FRAME_CNT_EN
  logic [vga_timing_pkg::FRAME_CNT_W-1:0] frame_cnt_q;

  // Assigned only on the wrap so the value is held between frame boundaries.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign vga.frame_count = frame_cnt_q;
`else
  assign vga.frame_count = '0;
`endif

endmodule
